muldiv_unit: RTL

//  Multi-cycle RV32M/RV64M execute unit covering all eight M-extension ops.

---
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multi-cycle M-extension unit.
interface muldiv_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit, one op in flight, valid/ready on both sides.
// Optional divide result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW       = $clog2(XLEN);
    localparam int MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state, state_n;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, quo_q, rem_q, dvs_q, result_q;
    logic            neg_q_q, neg_r_q;
    logic [CW-1:0]   cnt;

    function automatic logic [XLEN-1:0] mul_res(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ax, bx, p;
        logic              as, bs;
        // MULH: both signed; MULHSU: only rs1 signed; MUL low half is signedness-agnostic
        as = ((f[1:0] == 2'b01) || (f[1:0] == 2'b10)) && a[XLEN-1];
        bs = (f[1:0] == 2'b01) && b[XLEN-1];
        ax = {{XLEN{as}}, a};
        bx = {{XLEN{bs}}, b};
        p  = ax * bx;
        return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    logic ready, accept, is_div, div_sgn, a_neg, b_neg, div0, ovf, special, fast_done;
    logic hit, mul_last, div_last;
    logic [XLEN-1:0] a_mag, b_mag, spec_q, spec_r, spec_val, hit_val, fast_val, mul_out;

    assign ready   = rst_n && (state == S_IDLE);
    assign accept  = bus.in_valid && ready && !bus.flush;
    assign is_div  = bus.op[2];
    assign div_sgn = !bus.op[0];
    assign a_neg   = div_sgn && bus.rs1[XLEN-1];
    assign b_neg   = div_sgn && bus.rs2[XLEN-1];
    assign a_mag   = a_neg ? -bus.rs1 : bus.rs1;
    assign b_mag   = b_neg ? -bus.rs2 : bus.rs2;
    assign div0    = (bus.rs2 == '0);
    assign ovf     = div_sgn && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);
    assign special = div0 || ovf;
    assign spec_q  = div0 ? '1 : bus.rs1;
    assign spec_r  = div0 ? bus.rs1 : '0;
    assign spec_val = bus.op[1] ? spec_r : spec_q;

    // With a single-cycle multiply the product is taken straight from the request
    if (MUL_CYCLES == 1) begin : g_mul_comb
        assign mul_out = mul_res(bus.op, bus.rs1, bus.rs2);
    end else begin : g_mul_seq
        assign mul_out = mul_res(op_q, a_q, b_q);
    end

    assign fast_done = is_div ? (special || hit) : (MUL_CYCLES == 1);
    assign fast_val  = is_div ? (special ? spec_val : hit_val) : mul_out;
    assign mul_last  = (cnt == CW'(MUL_LAST));
    assign div_last  = (cnt == CW'(XLEN - 1));

    // Restoring step; the last step's output is sign-fixed on the same edge
    logic [XLEN:0]   shifted;
    logic            qbit;
    logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix, div_res;
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign qbit    = (shifted >= {1'b0, dvs_q});
    assign rem_n   = qbit ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], qbit};
    assign q_fix   = neg_q_q ? -quo_n : quo_n;
    assign r_fix   = neg_r_q ? -rem_n : rem_n;
    assign div_res = op_q[1] ? r_fix : q_fix;

`ifdef MULDIV_RESULT_CACHE_EN
    logic            c_vld, c_sgn, c_rem;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r;

    assign hit     = c_vld && (bus.rs1 == c_a) && (bus.rs2 == c_b) &&
                     (c_sgn == div_sgn) && (c_rem != bus.op[1]);
    assign hit_val = bus.op[1] ? c_r : c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= 1'b0; c_sgn <= 1'b0; c_rem <= 1'b0;
            c_a <= '0; c_b <= '0; c_q <= '0; c_r <= '0;
        end else if (bus.flush || (accept && !is_div)) begin
            c_vld <= 1'b0;
        end else if (accept && special) begin
            c_vld <= 1'b1; c_sgn <= div_sgn; c_rem <= bus.op[1];
            c_a <= bus.rs1; c_b <= bus.rs2; c_q <= spec_q; c_r <= spec_r;
        end else if (accept && hit) begin
            c_rem <= bus.op[1];
        end else if (state == S_DIV && div_last) begin
            c_vld <= 1'b1; c_sgn <= !op_q[0]; c_rem <= op_q[1];
            c_a <= a_q; c_b <= b_q; c_q <= q_fix; c_r <= r_fix;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_val = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = fast_done ? S_DONE : (is_div ? S_DIV : S_MUL);
            S_MUL:   if (mul_last) state_n = S_DONE;
            S_DIV:   if (div_last) state_n = S_DONE;
            S_DONE:  if (bus.out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (bus.flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0; a_q <= '0; b_q <= '0; cnt <= '0;
            quo_q <= '0; rem_q <= '0; dvs_q <= '0;
            neg_q_q <= 1'b0; neg_r_q <= 1'b0; result_q <= '0;
        end else if (accept) begin
            op_q    <= bus.op;
            a_q     <= bus.rs1;
            b_q     <= bus.rs2;
            cnt     <= '0;
            quo_q   <= a_mag;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            if (fast_done) result_q <= fast_val;
        end else if (state == S_MUL) begin
            cnt <= cnt + 1'b1;
            if (mul_last) result_q <= mul_out;
        end else if (state == S_DIV) begin
            cnt   <= cnt + 1'b1;
            quo_q <= quo_n;
            rem_q <= rem_n;
            if (div_last) result_q <= div_res;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
endmodule
